hasher_seq: RTL and testbench

- Iterative, parametrised successor to the combinational hasher.
- Absorbs one message byte per clock into one of NUM_LANES lane states, assigned round-robin. XORs the lanes and applies a data-dependent final rotation.
- Sits between a message source and a consumer, with a valid/ready handshake on both sides.
- Adds variable-length messages up to MAX_BYTES, configurable lane count, back-pressure and held results.

---
 rtl/hasher_seq_pkg.sv | 25 ++
 rtl/hasher_round_dyn.sv | 19 +
 rtl/rotator.sv | 18 +
 rtl/hasher_seq.sv | 150 +++++++++++++++
 tb/tb_hasher_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hasher_seq_pkg.sv
// rtl/hasher_seq_pkg.sv - shared constants, state encoding and rotate helpers for hasher_seq
package hasher_seq_pkg;

    localparam logic [31:0] HASH_SEED = 32'h55555555;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Doubling the word turns a rotate into a plain shift plus a slice.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] t;
        t = {x, x} << amt;
        return t[63:32];
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] t;
        t = {x, x} >> amt;
        return t[31:0];
    endfunction

endpackage

// File: rtl/hasher_round_dyn.sv
// rtl/hasher_round_dyn.sv - one absorb round with a runtime round index
module hasher_round_dyn
    import hasher_seq_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic [31:0]      in_state,
    input  logic [7:0]       in_byte,
    input  logic [LEN_W-1:0] round,
    output logic [31:0]      out_state
);

    // Rotation is 1..31, so a round never degenerates into the identity.
    logic [4:0] amt;

    assign amt       = 5'((32'(round) % 32'd31) + 32'd1);
    assign out_state = rotl32(in_state, amt) ^ {4{in_byte}};

endmodule

// File: rtl/rotator.sv
// rtl/rotator.sv - combinational barrel rotator, left or right by a runtime amount
module rotator #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  logic                     left,
    output logic [WIDTH-1:0]         data_out
);

    logic [2*WIDTH-1:0] shl;
    logic [2*WIDTH-1:0] shr;

    assign shl      = {data_in, data_in} << amount;
    assign shr      = {data_in, data_in} >> amount;
    assign data_out = left ? shl[2*WIDTH-1:WIDTH] : shr[WIDTH-1:0];

endmodule

// File: rtl/hasher_seq.sv
// rtl/hasher_seq.sv - iterative multi-lane byte hasher with valid/ready on both sides
module hasher_seq
    import hasher_seq_pkg::*;
#(
    parameter  int MAX_BYTES = 8,
    parameter  int NUM_LANES = 2,
    localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*MAX_BYTES-1:0] in_data,
    input  logic [LEN_W-1:0]       in_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_hash
);

    localparam int              LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

    state_t                 state;
    state_t                 state_next;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       count;
    logic [LANE_W-1:0]      lane_sel;
    logic [8*MAX_BYTES-1:0] data_q;
    logic [31:0]            lanes [NUM_LANES];
    logic [31:0]            lane_cur;
    logic [31:0]            round_out;
    logic [31:0]            fold;
    logic [31:0]            final_hash;
    logic [31:0]            hash_q;
    logic [LEN_W-1:0]       len_clamped;

    assign len_clamped = (in_len > LEN_MAX) ? LEN_MAX : in_len;
    assign out_hash    = hash_q;

    always_comb begin
        lane_cur = lanes[0];
        for (int i = 1; i < NUM_LANES; i++) begin
            if (lane_sel == LANE_W'(i)) begin
                lane_cur = lanes[i];
            end
        end
    end

    always_comb begin
        fold = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            fold = fold ^ lanes[i];
        end
    end

    // data_q shifts down one byte per round, so the current byte is always the low byte.
    hasher_round_dyn #(
        .LEN_W (LEN_W)
    ) u_round (
        .in_state  (lane_cur),
        .in_byte   (data_q[7:0]),
        .round     (count),
        .out_state (round_out)
    );

    // Empty messages rotate right so they do not collapse onto the left-rotate family.
    rotator #(
        .WIDTH (32)
    ) u_final_rot (
        .data_in  (fold),
        .amount   (fold[4:0]),
        .left     (len_q != '0),
        .data_out (final_hash)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == len_q) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            count    <= '0;
            lane_sel <= '0;
            data_q   <= '0;
            hash_q   <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lanes[i] <= rotl32(HASH_SEED, 5'(i % 32));
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        len_q    <= len_clamped;
                        count    <= '0;
                        lane_sel <= '0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            lanes[i] <= rotl32(HASH_SEED, 5'(i % 32));
                        end
                    end
                end
                RUN: begin
                    if (count != len_q) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (lane_sel == LANE_W'(i)) begin
                                lanes[i] <= round_out;
                            end
                        end
                        count  <= count + LEN_W'(1);
                        data_q <= data_q >> 8;
                        if (lane_sel == LANE_W'(NUM_LANES - 1)) begin
                            lane_sel <= '0;
                        end else begin
                            lane_sel <= lane_sel + LANE_W'(1);
                        end
                    end else begin
                        hash_q <= final_hash;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hasher_seq.sv
// tb/tb_hasher_seq.sv - directed and random checks of hasher_seq with 1, 2 and 4 lanes
module tb_hasher_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic [3:0]  in_len;
    logic        ir1, ir2, ir4;
    logic        ov1, ov2, ov4;
    logic [31:0] h1, h2, h4;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    hasher_seq #(.MAX_BYTES(8), .NUM_LANES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .in_len(in_len), .out_valid(ov1), .out_ready(out_ready), .out_hash(h1));
    hasher_seq #(.MAX_BYTES(8), .NUM_LANES(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .in_len(in_len), .out_valid(ov2), .out_ready(out_ready), .out_hash(h2));
    hasher_seq #(.MAX_BYTES(8), .NUM_LANES(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .in_len(in_len), .out_valid(ov4), .out_ready(out_ready), .out_hash(h4));

    function automatic logic [31:0] model(input logic [63:0] d, input int len, input int nl);
        logic [31:0] ln [4];
        logic [31:0] f;
        logic [7:0]  b;
        int          l, j, r, sh;
        l = (len > 8) ? 8 : len;
        for (int i = 0; i < 4; i++) ln[i] = (i % 2 == 0) ? 32'h55555555 : 32'hAAAAAAAA;
        for (int k = 0; k < l; k++) begin
            j = k % nl;
            r = (k % 31) + 1;
            b = d[8*k +: 8];
            ln[j] = ((ln[j] << r) | (ln[j] >> (32 - r))) ^ {b, b, b, b};
        end
        f = 32'h0;
        for (int i = 0; i < nl; i++) f = f ^ ln[i];
        sh = int'(f[4:0]);
        if (sh == 0) return f;
        if (l != 0) return (f << sh) | (f >> (32 - sh));
        return (f >> sh) | (f << (32 - sh));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_wait(input logic [63:0] d, input logic [3:0] l, input bit noise,
                                 output int edges);
        int guard;
        guard = 0;
        while (!(ir1 && ir2 && ir4) && guard < 50) begin
            tick;
            guard++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        tick;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom()};
        in_len   = 4'($urandom_range(0, 15));
        edges    = 0;
        while (!ov2 && edges < 40) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom(), $urandom()};
            end
            tick;
            edges++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_hash(input int hold, output bit stable, output bit ov_after,
                                output bit ir_after);
        logic [31:0] s1, s2, s4;
        s1 = h1;
        s2 = h2;
        s4 = h4;
        stable = 1'b1;
        out_ready = 1'b0;
        repeat (hold) begin
            tick;
            if (!(ov1 && ov2 && ov4) || h1 !== s1 || h2 !== s2 || h4 !== s4) stable = 1'b0;
            if (ir1 || ir2 || ir4) stable = 1'b0;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        ov_after = ov1 | ov2 | ov4;
        ir_after = ir1 & ir2 & ir4;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_len = '0;
        repeat (2) tick;
        reset = 1'b0;
        tests++;
        if ({ov1, ov2, ov4} !== 3'b000) begin
            fails++;
            $display("FAIL reset_out_valid: got %b want 000", {ov1, ov2, ov4});
        end
        tests++;
        if ({ir1, ir2, ir4} !== 3'b111) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 111", {ir1, ir2, ir4});
        end
        tests++;
        if ({h1, h2, h4} !== 96'h0) begin
            fails++;
            $display("FAIL reset_out_hash: got %h %h %h want 0", h1, h2, h4);
        end
    endtask

    task automatic test_len0;
        int e;
        bit st, ova, ira;
        send_and_wait(64'hDEADBEEF_01234567, 4'd0, 1'b0, e);
        tests++;
        if (e !== 1) begin
            fails++;
            $display("FAIL len0_latency: got %0d edges want 1", e);
        end
        tests++;
        if (h2 !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL len0_hash_l2: got %h want ffffffff", h2);
        end
        tests++;
        if (h1 !== 32'hAAAAAAAA) begin
            fails++;
            $display("FAIL len0_hash_l1: got %h want aaaaaaaa", h1);
        end
        tests++;
        if (h4 !== 32'h00000000) begin
            fails++;
            $display("FAIL len0_hash_l4: got %h want 00000000", h4);
        end
        release_hash(3, st, ova, ira);
        tests++;
        if (st !== 1'b1 || ova !== 1'b0 || ira !== 1'b1) begin
            fails++;
            $display("FAIL len0_handshake: got stable=%b ov=%b ir=%b want 1 0 1", st, ova, ira);
        end
    endtask

    task automatic test_short;
        int e;
        bit st, ova, ira;
        send_and_wait(64'h0, 4'd1, 1'b0, e);
        tests++;
        if (e !== 2 || h2 !== 32'h0 || h1 !== 32'hAAAAAAAA || h4 !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL len1_zero: got e=%0d %h %h %h want 2 00000000 aaaaaaaa ffffffff",
                     e, h2, h1, h4);
        end
        release_hash(0, st, ova, ira);
        send_and_wait(64'h0201, 4'd2, 1'b0, e);
        tests++;
        if (e !== 3 || h2 !== 32'h18181818 || h1 !== 32'hCACACACA || h4 !== 32'hCFCFCFCF) begin
            fails++;
            $display("FAIL len2_0102: got e=%0d %h %h %h want 3 18181818 cacacaca cfcfcfcf",
                     e, h2, h1, h4);
        end
        release_hash(0, st, ova, ira);
        tests++;
        if (ova !== 1'b0 || ira !== 1'b1) begin
            fails++;
            $display("FAIL len2_release: got ov=%b ir=%b want 0 1", ova, ira);
        end
    endtask

    task automatic test_backpressure_and_clamp;
        logic [63:0] d;
        logic [31:0] g2;
        int e;
        bit st, ova, ira;
        d = 64'h8C3E_19F4_A705_6B2D;
        send_and_wait(d, 4'd8, 1'b0, e);
        g2 = h2;
        tests++;
        if (e !== 9) begin
            fails++;
            $display("FAIL len8_latency: got %0d edges want 9", e);
        end
        tests++;
        if (h1 !== model(d, 8, 1) || h2 !== model(d, 8, 2) || h4 !== model(d, 8, 4)) begin
            fails++;
            $display("FAIL len8_hash: got %h %h %h want %h %h %h", h1, h2, h4,
                     model(d, 8, 1), model(d, 8, 2), model(d, 8, 4));
        end
        release_hash(5, st, ova, ira);
        tests++;
        if (st !== 1'b1 || ova !== 1'b0 || ira !== 1'b1) begin
            fails++;
            $display("FAIL len8_hold: got stable=%b ov=%b ir=%b want 1 0 1", st, ova, ira);
        end
        send_and_wait(d, 4'd15, 1'b0, e);
        tests++;
        if (e !== 9 || h2 !== g2 || h2 !== model(d, 8, 2)) begin
            fails++;
            $display("FAIL clamp15: got e=%0d hash %h want 9 %h", e, h2, model(d, 8, 2));
        end
        release_hash(1, st, ova, ira);
    endtask

    task automatic test_reset_mid_run;
        logic [63:0] d;
        int e;
        bit st, ova, ira;
        d = 64'h0F1E_2D3C_4B5A_6978;
        send_and_wait(d, 4'd8, 1'b0, e);
        release_hash(0, st, ova, ira);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = 4'd8;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tests++;
        if ({ov1, ov2, ov4} !== 3'b000 || {ir1, ir2, ir4} !== 3'b111) begin
            fails++;
            $display("FAIL reset_mid_run: got ov=%b ir=%b want 000 111",
                     {ov1, ov2, ov4}, {ir1, ir2, ir4});
        end
        send_and_wait(d, 4'd8, 1'b0, e);
        tests++;
        if (e !== 9 || h1 !== model(d, 8, 1) || h2 !== model(d, 8, 2) || h4 !== model(d, 8, 4)) begin
            fails++;
            $display("FAIL after_reset_hash: got e=%0d %h %h %h want 9 %h %h %h", e, h1, h2, h4,
                     model(d, 8, 1), model(d, 8, 2), model(d, 8, 4));
        end
        release_hash(0, st, ova, ira);
    endtask

    task automatic test_back_to_back;
        logic [63:0] d;
        logic [3:0]  l;
        int e, lc;
        bit st, ova, ira;
        for (int n = 0; n < 200; n++) begin
            d  = {$urandom(), $urandom()};
            l  = 4'($urandom_range(0, 15));
            lc = (int'(l) > 8) ? 8 : int'(l);
            send_and_wait(d, l, 1'b1, e);
            tests++;
            if (e !== lc + 1) begin
                fails++;
                $display("FAIL rand%0d_latency: got %0d want %0d", n, e, lc + 1);
            end
            tests++;
            if (h1 !== model(d, lc, 1) || h2 !== model(d, lc, 2) || h4 !== model(d, lc, 4)) begin
                fails++;
                $display("FAIL rand%0d_hash: got %h %h %h want %h %h %h", n, h1, h2, h4,
                         model(d, lc, 1), model(d, lc, 2), model(d, lc, 4));
            end
            release_hash($urandom_range(0, 3), st, ova, ira);
            tests++;
            if (st !== 1'b1 || ova !== 1'b0 || ira !== 1'b1) begin
                fails++;
                $display("FAIL rand%0d_handshake: got stable=%b ov=%b ir=%b want 1 0 1",
                         n, st, ova, ira);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_len0;
        test_short;
        test_backpressure_and_clamp;
        test_reset_mid_run;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
